// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM status, and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Load data returned to a requester whose RAM access ended in ERROR.
  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Cache-request and RAM bus bundle for mem_arbiter_ctrl.
// slave  : the arbiter side (takes cache requests and RAM status).
// master : the environment side (caches plus RAM model).
// Handshake: a requester raises iREN or dREN/dWEN with a stable address
// and holds them until its wait goes low; wait low for one cycle marks
// completion and qualifies the load data in that same cycle.
interface mem_arbiter_ctrl_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Icache starvation guard: counts dcache grants made while icache waits
// and raises force_i once the limit is reached. Built only when
// MEMARB_STARVE_GUARD_EN is defined.
`ifdef MEMARB_STARVE_GUARD_EN
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic idle,
  input  logic d_grant,
  input  logic i_grant,
  input  logic ipend,
  output logic force_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;

  // Count dcache wins over a pending icache; clear once icache wins or stops asking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (i_grant || (idle && !ipend)) begin
      cnt_q <= '0;
    end else if (d_grant && ipend && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_i = (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/mem_arbiter_ctrl.sv
// Memory-side arbiter between icache and dcache for a single-ported RAM.
// Optional icache starvation guard: define MEMARB_STARVE_GUARD_EN.
module mem_arbiter_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  mem_arbiter_ctrl_if.slave  bus,
  output arb_state_t         dbg_state
);

  arb_state_t state_q, state_d;
  word_t      addr_q, store_q;
  logic       wr_q;
  logic       err_q;
  logic       grant_i, grant_d, set_err, force_i;

  logic  iwait, dwait, ram_ren, ram_wen;
  word_t iload, dload;

`ifdef MEMARB_STARVE_GUARD_EN
  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .CLK     (CLK),
    .RST     (RST),
    .idle    (state_q == IDLE),
    .d_grant (grant_d),
    .i_grant (grant_i),
    .ipend   (bus.iREN),
    .force_i (force_i)
  );
`else
  // Strict dcache priority: icache is never forced (expression is constant false).
  assign force_i = (STARVE_LIMIT < 0);
`endif

  // Next state, grant selection and per-state outputs.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    set_err = 1'b0;
    iwait   = 1'b1;
    dwait   = 1'b1;
    iload   = '0;
    dload   = '0;
    ram_ren = 1'b0;
    ram_wen = 1'b0;
    case (state_q)
      IDLE: begin
        if (force_i && bus.iREN) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end else if (bus.dREN || bus.dWEN) begin
          grant_d = 1'b1;
          state_d = SERVE_D;
        end else if (bus.iREN) begin
          grant_i = 1'b1;
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        ram_ren = 1'b1;
        if (bus.ramstate == ACCESS) begin
          iwait   = 1'b0;
          iload   = bus.ramload;
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          iwait   = 1'b0;
          iload   = ARB_ERR_WORD;
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        ram_ren = !wr_q;
        ram_wen = wr_q;
        if (bus.ramstate == ACCESS) begin
          dwait   = 1'b0;
          dload   = wr_q ? '0 : bus.ramload;
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          dwait   = 1'b0;
          dload   = ARB_ERR_WORD;
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus latched copy of the granted request and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        addr_q  <= bus.iaddr;
        store_q <= '0;
        wr_q    <= 1'b0;
      end else if (grant_d) begin
        addr_q  <= bus.daddr;
        store_q <= bus.dstore;
        wr_q    <= bus.dWEN;
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  assign bus.iwait    = iwait;
  assign bus.iload    = iload;
  assign bus.dwait    = dwait;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.err      = err_q;
  assign dbg_state    = state_q;

endmodule
